// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC -> word read -> decode handshake.
// Optional FETCH_MISALIGN_EN turns misaligned PCs into NOP + flag.
module fetch_unit #(
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misaligned
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ISSUE,
    REQ,
    DROP,
    HOLD
  } state_t;

  state_t state;
  logic   mis_pc;

`ifdef FETCH_MISALIGN_EN
  logic mis_q;
  assign mis_pc     = |pc[1:0];
  assign misaligned = mis_q;
`else
  assign mis_pc     = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Advance only on a real handshake; a redirect owns the PC this cycle.
  assign pc_en = (state == HOLD) & instr_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ISSUE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= INSTR_NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        ISSUE: begin
          mem_addr <= pc & ALIGN_MASK;
          if (flush) begin
            state <= ISSUE;
          end else if (mis_pc) begin
            instr       <= INSTR_NOP;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
`ifdef FETCH_MISALIGN_EN
            mis_q       <= 1'b1;
`endif
            state       <= HOLD;
          end else begin
            mem_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (flush) begin
              state <= ISSUE;
            end else begin
              instr       <= mem_rdata;
              instr_pc    <= mem_addr;
              instr_valid <= 1'b1;
`ifdef FETCH_MISALIGN_EN
              mis_q       <= 1'b0;
`endif
              state       <= HOLD;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        // Request stays up until acked; its data is thrown away.
        DROP: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ISSUE;
          end
        end
        HOLD: begin
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, corner sequences, random run
// against a PC/memory model and stream invariants.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_en;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        misaligned;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_en       (pc_en),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;

  // memory model state
  int wcnt = 0;
  int next_wait = 0;
  bit rnd_wait = 1'b0;

  // what happened in the last applied cycle
  bit          have_prev = 1'b0;
  bit          fl_s, pcen_s, req_s, ack_s;
  logic [31:0] tgt_s, addr_s;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input bit rdy, input bit fl,
                       input logic [31:0] tgt);
    bit mis;
    instr_ready = rdy;
    flush       = fl;
    mem_ack     = mem_req && (wcnt >= next_wait);
    mem_rdata   = mem_ack ? memf(mem_addr) : 32'hDEAD_BEEF;
    #1;
    chk("pc_en", {31'd0, pc_en}, {31'd0, instr_valid & rdy & ~fl});
    if (instr_valid) begin
      mis = MIS_EN && (pc[1:0] != 2'b00);
      chk("instr_pc", instr_pc, MIS_EN ? pc : (pc & ~32'h3));
      chk("instr", instr, mis ? NOP : memf(pc & ~32'h3));
      chk("misaligned", {31'd0, misaligned}, {31'd0, mis});
    end
    if (have_prev && req_s && !ack_s) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_held", mem_addr, addr_s);
    end
    if (mem_req) chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
    if (instr_valid && rdy && !fl) n_hs++;
    fl_s   = fl;
    tgt_s  = tgt;
    pcen_s = pc_en;
    req_s  = mem_req;
    ack_s  = mem_ack;
    addr_s = mem_addr;
    have_prev = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (fl_s) pc = tgt_s;
    else if (pcen_s) pc = pc + 32'd4;
    if (req_s && ack_s) begin
      wcnt = 0;
      if (rnd_wait) next_wait = $urandom_range(0, 3);
    end else if (req_s) begin
      wcnt++;
    end
  endtask

  task automatic do_reset(input logic [31:0] p);
    reset = 1'b1;
    flush = 1'b0;
    instr_ready = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pc = p;
    wcnt = 0;
    have_prev = 1'b0;
  endtask

  // run until mem_req (want_valid=0) or instr_valid is up, unapplied
  task automatic seek(input bit want_valid, input bit rdy);
    for (int i = 0; i < 20; i++) begin
      if (want_valid ? instr_valid : mem_req) return;
      apply(rdy, 1'b0, '0);
      adv();
    end
    chk("seek_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_val;
    bit          e_pcen;
    logic [31:0] e_instr;
  } vec_t;

  vec_t        tv[6];
  logic [31:0] a0, i1, p1;
  int          cnt, h0;
  bit          r, f;
  logic [31:0] t;

  initial begin
    tv[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0050_0093};
    tv[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[4] = '{1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0};
    tv[5] = '{1'b1, 1'b0, 32'h4, 1'b1, 1'b1, memf(32'h4)};

    do_reset(32'h0);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);

    // first fetches after reset, zero-wait memory
    for (int c = 0; c < 6; c++) begin
      apply(tv[c].rdy, 1'b0, '0);
      chk($sformatf("tv%0d_req", c), {31'd0, mem_req},
          {31'd0, tv[c].e_req});
      chk($sformatf("tv%0d_addr", c), mem_addr, tv[c].e_addr);
      chk($sformatf("tv%0d_valid", c), {31'd0, instr_valid},
          {31'd0, tv[c].e_val});
      chk($sformatf("tv%0d_pc_en", c), {31'd0, pc_en},
          {31'd0, tv[c].e_pcen});
      if (tv[c].e_val) chk($sformatf("tv%0d_instr", c), instr,
                           tv[c].e_instr);
      adv();
    end

    // three wait states
    next_wait = 3;
    seek(1'b0, 1'b1);
    a0 = mem_addr;
    cnt = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      apply(1'b1, 1'b0, '0);
      chk("wait_addr", mem_addr, a0);
      cnt++;
      adv();
    end
    chk("wait_len", cnt, 32'd4);
    next_wait = 0;
    apply(1'b1, 1'b0, '0);
    chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    adv();

    // decode stalls for five cycles
    seek(1'b1, 1'b0);
    i1 = instr;
    p1 = instr_pc;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, '0);
      chk("stall_instr", instr, i1);
      chk("stall_ipc", instr_pc, p1);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
      adv();
    end
    apply(1'b1, 1'b0, '0);
    chk("stall_hs", {31'd0, pc_en}, 32'd1);
    adv();

    // flush while request is waiting
    next_wait = 3;
    seek(1'b0, 1'b1);
    apply(1'b1, 1'b1, 32'h100);
    a0 = mem_addr;
    adv();
    cnt = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      apply(1'b1, 1'b0, '0);
      chk("drop_addr", mem_addr, a0);
      chk("drop_valid", {31'd0, instr_valid}, 32'd0);
      cnt++;
      adv();
    end
    chk("drop_len", cnt, 32'd3);
    next_wait = 0;
    apply(1'b1, 1'b0, '0);
    chk("drop_issue_valid", {31'd0, instr_valid}, 32'd0);
    chk("drop_issue_req", {31'd0, mem_req}, 32'd0);
    adv();
    apply(1'b1, 1'b0, '0);
    chk("redir_req", {31'd0, mem_req}, 32'd1);
    chk("redir_addr", mem_addr, 32'h100);
    adv();

    // flush and ready together in HOLD
    seek(1'b1, 1'b1);
    apply(1'b1, 1'b1, 32'h200);
    chk("hflush_pc_en", {31'd0, pc_en}, 32'd0);
    adv();
    apply(1'b1, 1'b0, '0);
    chk("hflush_valid", {31'd0, instr_valid}, 32'd0);
    adv();
    apply(1'b1, 1'b0, '0);
    chk("hflush_req", {31'd0, mem_req}, 32'd1);
    chk("hflush_addr", mem_addr, 32'h200);
    adv();

`ifdef FETCH_MISALIGN_EN
    seek(1'b1, 1'b1);
    apply(1'b1, 1'b1, 32'h102);
    adv();
    apply(1'b1, 1'b0, '0);
    chk("mis_issue_req", {31'd0, mem_req}, 32'd0);
    adv();
    apply(1'b0, 1'b0, '0);
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd1);
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_instr", instr, NOP);
    chk("mis_ipc", instr_pc, 32'h102);
    adv();
    apply(1'b1, 1'b1, 32'h300);
    adv();
`endif

    // random traffic against the model
    rnd_wait = 1'b1;
    next_wait = $urandom_range(0, 3);
    h0 = n_hs;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(32'h40);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      t = $urandom & 32'h0000_FFF0;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      apply(r, f, t);
      adv();
    end
    chk("rnd_progress", {31'd0, (n_hs - h0) > 100}, 32'd1);

    // steady-state throughput: one instruction per three cycles
    rnd_wait = 1'b0;
    next_wait = 0;
    do_reset(32'h1000);
    h0 = n_hs;
    for (int i = 0; i < 30; i++) begin
      apply(1'b1, 1'b0, '0);
      adv();
    end
    chk("throughput", n_hs - h0, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
